instr_sequencer: RTL and testbench

- Drives the processor's `opcode` input from a synchronous instruction memory and collects each `result` value.
- It plays the stimulus role in silicon rather than in simulation: it fetches instructions, holds each one stable for a fixed latency, and samples the result.
- Each sampled result is presented on a valid/ready stream to a downstream logger or checker.
- It sits between instruction memory, the Processor and the result sink.

---
 rtl/proc_pkg.sv | 38 +++
 rtl/instr_sequencer.sv | 121 ++++++++++++
 tb/tb_instr_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction word layout, op codes and the
// sequencer state encoding used by the instruction sequencer.
package proc_pkg;

    localparam int OPCODE_W = 16;
    localparam logic [OPCODE_W-1:0] HALT_WORD_DEF = 16'hFFFF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RA_MSB  = 12;
    localparam int RA_LSB  = 10;
    localparam int RB_MSB  = 9;
    localparam int RB_LSB  = 7;
    localparam int RC_MSB  = 6;
    localparam int RC_LSB  = 4;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_SUBI = 3'b010,
        OP_SUB  = 3'b011
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        CAPTURE,
        DONE
    } seq_state_e;

    function automatic logic [2:0] op_field(input logic [OPCODE_W-1:0] word);
        return word[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Fetches instructions from a synchronous memory, holds each on opcode for
// RESULT_LAT cycles, samples the processor result and streams it out.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int                    ADDR_W     = 8,
    parameter int                    RESULT_LAT = 1,
    parameter logic [OPCODE_W-1:0]   HALT_WORD  = HALT_WORD_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   last_addr,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [15:0]         imem_data,
    output logic [15:0]         opcode,
    input  logic [15:0]         result,
    output logic [15:0]         res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     instr_count
);

    seq_state_e           state_reg;
    logic [ADDR_W-1:0]    pc_reg;
    logic [ADDR_W-1:0]    last_addr_reg;
    logic [ADDR_W-1:0]    imem_addr_reg;
    logic [3:0]           lat_cnt_reg;
    logic [15:0]          opcode_reg;
    logic [15:0]          res_data_reg;
    logic                 res_valid_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [ADDR_W:0]      instr_count_reg;

    logic                 at_last;
    assign at_last = (pc_reg == last_addr_reg);

    // The memory has one cycle of read latency and FETCH lasts one cycle, so
    // the next address is presented as soon as the current word is consumed.
    // Parking the address at 0 in IDLE/DONE makes a restart fetch word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            pc_reg          <= '0;
            last_addr_reg   <= '0;
            imem_addr_reg   <= '0;
            lat_cnt_reg     <= '0;
            opcode_reg      <= '0;
            res_data_reg    <= '0;
            res_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            instr_count_reg <= '0;
        end else begin
            unique case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        last_addr_reg   <= last_addr;
                        pc_reg          <= '0;
                        imem_addr_reg   <= '0;
                        instr_count_reg <= '0;
                        busy_reg        <= 1'b1;
                        done_reg        <= 1'b0;
                        state_reg       <= FETCH;
                    end
                end
                FETCH: begin
                    if (imem_data == HALT_WORD) begin
                        imem_addr_reg <= '0;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        opcode_reg      <= imem_data;
                        instr_count_reg <= instr_count_reg + (ADDR_W+1)'(1);
                        lat_cnt_reg     <= 4'(RESULT_LAT - 1);
                        imem_addr_reg   <= at_last ? '0 : pc_reg + ADDR_W'(1);
                        state_reg       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lat_cnt_reg != 4'd0) begin
                        lat_cnt_reg <= lat_cnt_reg - 4'd1;
                    end else begin
                        res_data_reg  <= result;
                        res_valid_reg <= 1'b1;
                        state_reg     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (res_valid_reg && res_ready) begin
                        res_valid_reg <= 1'b0;
                        if (at_last) begin
                            imem_addr_reg <= '0;
                            busy_reg      <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            pc_reg        <= pc_reg + ADDR_W'(1);
                            imem_addr_reg <= pc_reg + ADDR_W'(1);
                            state_reg     <= FETCH;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign imem_addr   = imem_addr_reg;
    assign opcode      = opcode_reg;
    assign res_data    = res_data_reg;
    assign res_valid   = res_valid_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed program runs plus random
// programs/back-pressure compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_instr_sequencer;

    localparam int ADDR_W = 8;
    localparam int LAT    = 1;
    localparam int LAT3   = 3;
    localparam logic [15:0] W_ADD  = 16'b000_000_001_010_0000;
    localparam logic [15:0] W_ADDI = 16'b001_000_001_000_0001;
    localparam logic [15:0] W_SUBI = 16'b010_000_001_000_0001;
    localparam logic [15:0] W_SUB  = 16'b011_000_001_010_0000;
    localparam logic [15:0] HALT   = 16'hFFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, res_ready, res_valid, busy, done;
    logic [ADDR_W-1:0] last_addr, imem_addr;
    logic [15:0]       imem_data, opcode, result, res_data;
    logic [ADDR_W:0]   instr_count;

    logic              start3, res_ready3, res_valid3, busy3, done3;
    logic [ADDR_W-1:0] last_addr3, imem_addr3;
    logic [15:0]       imem_data3, opcode3, result3, res_data3;
    logic [ADDR_W:0]   instr_count3;

    logic [15:0] mem [0:255];
    logic        use_full;
    logic        rand_ready;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    int          hs_count;

    instr_sequencer #(.ADDR_W(ADDR_W), .RESULT_LAT(LAT), .HALT_WORD(HALT)) dut (
        .clk(clk), .rst(rst), .start(start), .last_addr(last_addr),
        .imem_addr(imem_addr), .imem_data(imem_data), .opcode(opcode),
        .result(result), .res_data(res_data), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .done(done), .instr_count(instr_count)
    );

    instr_sequencer #(.ADDR_W(ADDR_W), .RESULT_LAT(LAT3), .HALT_WORD(HALT)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .last_addr(last_addr3),
        .imem_addr(imem_addr3), .imem_data(imem_data3), .opcode(opcode3),
        .result(result3), .res_data(res_data3), .res_valid(res_valid3),
        .res_ready(res_ready3), .busy(busy3), .done(done3), .instr_count(instr_count3)
    );

    // Instruction memory: one-cycle read latency
    always @(posedge clk) begin
        imem_data  <= mem[imem_addr];
        imem_data3 <= mem[imem_addr3];
    end

    function automatic logic [15:0] proc_fn(input logic [15:0] op, input logic full);
        if (full) return (op ^ 16'hA5C3) + 16'd3;
        return {12'd0, op[3:0]} + 16'd7;
    endfunction

    assign result  = proc_fn(opcode, use_full);
    assign result3 = proc_fn(opcode3, 1'b0);

    always @(negedge clk) begin
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            got.push_back(res_data);
            hs_count++;
            $display("HS %0d data=%h count=%0d", hs_count, res_data, instr_count);
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 res_ready = 1'($urandom_range(0, 1));
        end
    end

    // Reference: every word up to last_addr is issued in order until a halt word.
    task automatic model_run(input int last, input logic full);
        exp_q.delete();
        for (int a = 0; a <= last; a++) begin
            if (mem[a] == HALT) break;
            exp_q.push_back(proc_fn(mem[a], full));
        end
    endtask

    task automatic load_prog4();
        mem[0] = W_ADD; mem[1] = W_ADDI; mem[2] = W_SUBI; mem[3] = W_SUB; mem[4] = HALT;
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] la);
        @(posedge clk); #1 start = 1'b1; last_addr = la;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output logic ok);
        cycles = 0; ok = 1'b0;
        while (cycles < budget) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; last_addr = '0; res_ready = 1'b1; rand_ready = 1'b0;
        start3 = 1'b0; last_addr3 = '0; res_ready3 = 1'b1; use_full = 1'b0;
        got.delete(); hs_count = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_addr !== '0)   begin errors++; $display("FAIL reset_imem_addr got=%h exp=0", imem_addr); end
        checks++; if (opcode !== 16'h0)   begin errors++; $display("FAIL reset_opcode got=%h exp=0", opcode); end
        checks++; if (res_data !== 16'h0) begin errors++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (instr_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", instr_count); end
    endtask

    task automatic test_program();
        int cyc; logic ok;
        load_prog4(); use_full = 1'b0; res_ready = 1'b1;
        model_run(3, 1'b0);
        got.delete(); hs_count = 0;
        pulse_start(8'd3);
        wait_done(200, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL prog_timeout got=not_done exp=done"); end
        checks++; if (cyc != 4 * (LAT + 2)) begin errors++; $display("FAIL prog_done_time got=%0d exp=%0d", cyc, 4 * (LAT + 2)); end
        checks++; if (instr_count !== 9'd4) begin errors++; $display("FAIL prog_count got=%0d exp=4", instr_count); end
        checks++; if (got.size() != 4) begin errors++; $display("FAIL prog_len got=%0d exp=4", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL prog_res%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        int cyc, n; logic ok;
        load_prog4(); use_full = 1'b0; res_ready = 1'b1;
        model_run(3, 1'b0);
        got.delete(); hs_count = 0;
        pulse_start(8'd3);
        n = 0;
        do begin @(negedge clk); n++; end while (!(hs_count == 1 && res_valid === 1'b0) && n < 50);
        res_ready = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_wait_valid got=%b exp=1", res_valid); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (res_data !== 16'd8) begin errors++; $display("FAIL stall_data%0d got=%h exp=0008", k, res_data); end
            checks++; if (opcode !== W_ADDI)  begin errors++; $display("FAIL stall_opcode%0d got=%h exp=%h", k, opcode, W_ADDI); end
            checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d got=%b exp=1", k, res_valid); end
            if (k < 4) @(negedge clk);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        wait_done(200, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got=not_done exp=done"); end
        checks++; if (hs_count != 4) begin errors++; $display("FAIL stall_handshakes got=%0d exp=4", hs_count); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL stall_res%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_halt();
        int cyc; logic ok;
        mem[0] = W_ADD; mem[1] = HALT; mem[2] = W_SUB;
        use_full = 1'b0; res_ready = 1'b1;
        model_run(2, 1'b0);
        got.delete(); hs_count = 0;
        pulse_start(8'd2);
        wait_done(200, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL halt_timeout got=not_done exp=done"); end
        checks++; if (cyc != (LAT + 2) + 1) begin errors++; $display("FAIL halt_done_time got=%0d exp=%0d", cyc, LAT + 3); end
        checks++; if (instr_count !== 9'd1) begin errors++; $display("FAIL halt_count got=%0d exp=1", instr_count); end
        checks++; if (opcode !== W_ADD) begin errors++; $display("FAIL halt_opcode got=%h exp=%h", opcode, W_ADD); end
        checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL halt_len got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL halt_res%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int cyc, n; logic ok;
        load_prog4(); use_full = 1'b0; res_ready = 1'b1;
        got.delete(); hs_count = 0;
        pulse_start(8'd3);
        n = 0;
        do begin @(negedge clk); n++; end while (instr_count !== 9'd3 && n < 50);
        res_ready = 1'b0;
        n = 0;
        while (res_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL rmid_wait_valid got=%b exp=1", res_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (res_valid !== 1'b0)   begin errors++; $display("FAIL rmid_valid got=%b exp=0", res_valid); end
        checks++; if (opcode !== 16'h0)     begin errors++; $display("FAIL rmid_opcode got=%h exp=0", opcode); end
        checks++; if (instr_count !== '0)   begin errors++; $display("FAIL rmid_count got=%0d exp=0", instr_count); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rmid_state got=busy%b_done%b exp=idle", busy, done); end
        checks++; if (hs_count != 2) begin errors++; $display("FAIL rmid_handshakes got=%0d exp=2", hs_count); end
        res_ready = 1'b1;
        model_run(0, 1'b0);
        got.delete(); hs_count = 0;
        pulse_start(8'd0);
        wait_done(100, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_timeout got=not_done exp=done"); end
        checks++; if (got.size() != 1) begin errors++; $display("FAIL rmid_len got=%0d exp=1", got.size()); end
        if (got.size() > 0) begin
            checks++; if (got[0] !== exp_q[0]) begin errors++; $display("FAIL rmid_res got=%h exp=%h", got[0], exp_q[0]); end
        end
    endtask

    task automatic test_start_busy();
        int cyc; logic ok;
        load_prog4(); use_full = 1'b0; res_ready = 1'b1;
        model_run(3, 1'b0);
        got.delete(); hs_count = 0;
        pulse_start(8'd3);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; last_addr = 8'd0;
        @(posedge clk); #1 start = 1'b0;
        wait_done(200, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL busy_timeout got=not_done exp=done"); end
        checks++; if (instr_count !== 9'd4) begin errors++; $display("FAIL busy_count got=%0d exp=4", instr_count); end
        checks++; if (hs_count != 4) begin errors++; $display("FAIL busy_handshakes got=%0d exp=4", hs_count); end
        got.delete(); hs_count = 0;
        pulse_start(8'd3);
        @(negedge clk);
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL restart_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL restart_busy got=%b exp=1", busy); end
        checks++; if (instr_count !== '0)  begin errors++; $display("FAIL restart_count got=%0d exp=0", instr_count); end
        wait_done(200, cyc, ok);
        checks++; if (!ok || got.size() != 4) begin errors++; $display("FAIL restart_len got=%0d exp=4", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL restart_res%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    // Counts sampled cycles showing the new opcode, up to and including the
    // first cycle with res_valid high.
    task automatic test_latency();
        int n, lat;
        mem[0] = W_ADDI;
        @(posedge clk); #1 start3 = 1'b1; last_addr3 = 8'd0;
        @(posedge clk); #1 start3 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (opcode3 !== W_ADDI && n < 50);
        lat = 1;
        while (res_valid3 !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        checks++; if (lat != LAT3 + 1) begin errors++; $display("FAIL lat3_cycles got=%0d exp=%0d", lat, LAT3 + 1); end
        checks++; if (res_data3 !== 16'd8) begin errors++; $display("FAIL lat3_data got=%h exp=0008", res_data3); end
        n = 0;
        while (done3 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++; if (done3 !== 1'b1 || instr_count3 !== 9'd1) begin errors++; $display("FAIL lat3_done got=done%b_cnt%0d exp=done1_cnt1", done3, instr_count3); end
    endtask

    task automatic test_random();
        int cyc, last; logic ok;
        use_full = 1'b1; rand_ready = 1'b1;
        for (int it = 0; it < 6; it++) begin
            last = $urandom_range(0, 20);
            for (int a = 0; a <= last + 1; a++)
                mem[a] = ($urandom_range(0, 7) == 0) ? HALT : 16'($urandom);
            model_run(last, 1'b1);
            got.delete(); hs_count = 0;
            pulse_start(8'(last));
            wait_done((last + 1) * 40 + 20, cyc, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rand%0d_timeout got=not_done exp=done", it); end
            checks++; if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, got.size(), exp_q.size()); end
            checks++; if (instr_count !== 9'(exp_q.size())) begin errors++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, instr_count, exp_q.size()); end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_res%0d got=%h exp=%h", it, i, got[i], exp_q[i]); end
            end
        end
        rand_ready = 1'b0;
        @(posedge clk); #2 res_ready = 1'b1;
    endtask

    task automatic test_full();
        int cyc; logic ok;
        use_full = 1'b1; res_ready = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 16'($urandom) & 16'h7FFF;
        model_run(255, 1'b1);
        got.delete(); hs_count = 0;
        pulse_start(8'd255);
        wait_done(256 * (LAT + 2) + 20, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout got=not_done exp=done"); end
        checks++; if (cyc != 256 * (LAT + 2)) begin errors++; $display("FAIL full_done_time got=%0d exp=%0d", cyc, 256 * (LAT + 2)); end
        checks++; if (instr_count !== 9'd256) begin errors++; $display("FAIL full_count got=%0d exp=256", instr_count); end
        checks++; if (got.size() != 256) begin errors++; $display("FAIL full_len got=%0d exp=256", got.size()); end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL full_res%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_program();
        test_stall();
        test_halt();
        test_reset_mid();
        test_start_busy();
        test_latency();
        test_random();
        test_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
